// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Purpose:
//   Instruction fetch front end. Keeps the fetch PC and issues one
//   instruction-memory request at a time. It holds the returned word in a
//   single-entry fetch buffer until decode takes it. A taken branch or jump
//   (redirect) moves the PC and flushes the buffer. It also discards the
//   response of any request that was in flight when the redirect arrived.
//
// Ports:
//   clk              single clock, rising-edge active
//   reset            asynchronous, active-high reset
//   imem_req         request valid towards instruction memory
//   imem_addr        word-aligned fetch address (valid with imem_req)
//   imem_gnt         memory accepts the request this cycle
//   imem_rvalid      memory returns read data this cycle
//   imem_rdata       returned instruction word
//   instr_valid      fetch buffer holds an instruction for decode
//   instr            buffered instruction word
//   instr_pc         address the buffered instruction came from
//   instr_ready      decode consumes the buffer this cycle
//   redirect         taken branch/jump from execute
//   redirect_target  new fetch address (low two bits ignored)
//   pc_out           current fetch PC
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  // Set while a request that was overtaken by a redirect is still in flight.
  // Its response must be swallowed, and no new request may be issued before
  // that response arrives.
  logic        r_kill;

  // True when a granted request will still be awaiting its response after
  // this clock edge. A redirect in that situation has to arm the kill flag.
  logic        w_outstanding;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_inc;

  assign w_outstanding = (r_state == S_REQ && r_imem_req && imem_gnt) ||
                         ((r_state == S_WAIT || r_kill) && !imem_rvalid);
  assign w_redirect_pc = redirect_target & ~32'h0000_0003;
  // Wraps naturally from 32'hFFFF_FFFC to 32'h0000_0000.
  assign w_pc_inc      = r_pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_kill        <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over grant, response and consume in the same cycle.
      // The buffer is flushed and fetching restarts at the target. If a
      // request is still in flight, the new request is held back until the
      // stale response has been drained.
      r_state       <= S_REQ;
      r_pc          <= w_redirect_pc;
      r_instr_valid <= 1'b0;
      r_kill        <= w_outstanding;
      r_imem_req    <= !w_outstanding;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
        end

        S_REQ: begin
          if (r_kill) begin
            // Drain the response of the killed request, then start the
            // request for the redirected PC.
            if (imem_rvalid) begin
              r_kill     <= 1'b0;
              r_imem_req <= 1'b1;
            end
          end else if (imem_gnt) begin
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= w_pc_inc;
            r_state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
            r_imem_req    <= 1'b1;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_kill        <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed bench for fetch_controller. Inputs change and outputs are checked
// on the falling edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;

  int checks_cnt;
  int errors_cnt;

  fetch_controller #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .pc_out         (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Starts at a falling edge with the DUT in REQ and a request for
  // addr_exp on the bus. Completes one fetch with single-cycle grant and
  // response. The instruction is then held for hold_cyc cycles while stray
  // responses are driven, and is finally consumed. Ends at a falling edge in
  // REQ for next_exp.
  task automatic fetch_one(input logic [31:0] addr_exp, input logic [31:0] next_exp,
                           input logic [31:0] data, input int hold_cyc);
    check("req_valid", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, addr_exp);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req", {31'd0, imem_req}, 32'd0);
    check("wait_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("load_valid", {31'd0, instr_valid}, 32'd1);
    check("load_instr", instr, data);
    check("load_pc", instr_pc, addr_exp);
    check("pc_inc", pc_out, next_exp);
    for (int i = 0; i < hold_cyc; i++) begin
      // Responses outside WAIT must not disturb the buffer.
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0000 | i;
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, data);
      check("hold_pc", instr_pc, addr_exp);
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("cons_valid", {31'd0, instr_valid}, 32'd0);
    check("next_req", {31'd0, imem_req}, 32'd1);
    check("next_addr", imem_addr, next_exp);
    $display("fetch pc=0x%08h instr=0x%08h hold=%0d", addr_exp, data, hold_cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks_cnt      = 0;
    errors_cnt      = 0;
    reset           = 1'b1;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc_out, 32'h0000_0000);
    check("rst_instr", instr, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    $display("reset released, fetch begins");

    // Back-to-back sequential fetches.
    fetch_one(32'h0000_0000, 32'h0000_0004, 32'h1111_0000, 0);
    fetch_one(32'h0000_0004, 32'h0000_0008, 32'h2222_0004, 0);
    fetch_one(32'h0000_0008, 32'h0000_000C, 32'h3333_0008, 0);

    // Grant withheld for three cycles: request and address held stable.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, 32'h0000_0000);
      @(negedge clk);
    end
    $display("grant stalled 3 cycles at 0x00000000");
    fetch_one(32'h0000_0000, 32'h0000_0004, 32'hA000_0000, 0);

    // Decode back-pressure for five cycles.
    fetch_one(32'h0000_0004, 32'h0000_0008, 32'hB000_0004, 5);

    // Redirect while the response is outstanding: the response is dropped.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt        = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    check("kill_req", {31'd0, imem_req}, 32'd0);
    check("kill_pc", pc_out, 32'h0000_0100);
    check("kill_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0008;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("drop_valid", {31'd0, instr_valid}, 32'd0);
    check("drop_pc", pc_out, 32'h0000_0100);
    $display("redirect in WAIT to 0x00000103, stale response dropped");
    fetch_one(32'h0000_0100, 32'h0000_0104, 32'hC000_0100, 0);

    // Redirect coincident with the response.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt        = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0200;
    imem_rvalid     = 1'b1;
    imem_rdata      = 32'hDEAD_0104;
    @(negedge clk);
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    check("coin_valid", {31'd0, instr_valid}, 32'd0);
    check("coin_req", {31'd0, imem_req}, 32'd1);
    check("coin_addr", imem_addr, 32'h0000_0200);
    $display("redirect with response to 0x00000200");

    // Redirect together with consume in HOLD.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hD000_0200;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("h_valid", {31'd0, instr_valid}, 32'd1);
    check("h_instr", instr, 32'hD000_0200);
    instr_ready     = 1'b1;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0300;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect    = 1'b0;
    check("hr_valid", {31'd0, instr_valid}, 32'd0);
    check("hr_req", {31'd0, imem_req}, 32'd1);
    check("hr_addr", imem_addr, 32'h0000_0300);
    @(negedge clk);
    check("hr_valid2", {31'd0, instr_valid}, 32'd0);
    $display("redirect with consume in HOLD to 0x00000300");

    // Redirect to the top word, then wrap to zero.
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h0000_0000, 32'hE000_FFFC, 0);
    check("wrap_pc", pc_out, 32'h0000_0000);

    // Reset asserted in WAIT, late response after release is ignored.
    fetch_one(32'h0000_0000, 32'h0000_0004, 32'hF000_0000, 0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    reset    = 1'b1;
    #1;
    check("arst_pc", pc_out, 32'h0000_0000);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0004;
    @(negedge clk);
    check("late_valid", {31'd0, instr_valid}, 32'd0);
    check("late_req", {31'd0, imem_req}, 32'd1);
    check("late_addr", imem_addr, 32'h0000_0000);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("late2_valid", {31'd0, instr_valid}, 32'd0);
    check("late2_pc", pc_out, 32'h0000_0000);
    $display("reset in WAIT, late responses ignored");
    fetch_one(32'h0000_0000, 32'h0000_0004, 32'h5555_0000, 0);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_gnt  input  1  memory accepts request this cycle when imem_req=1.
REQ-007 imem_rvalid  input  1  read data returned this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-009 instr_valid  output  1  fetch buffer holds an instruction for decode.
REQ-010 instr  output  32  buffered instruction word.
REQ-011 instr_pc  output  32  address the buffered instruction was fetched from.
REQ-012 instr_ready  input  1  decode consumes the buffer this cycle when instr_valid=1.
REQ-013 redirect  input  1  taken branch/jump from execute (PCSrc=1).
REQ-014 redirect_target  input  32  new fetch address (PC + immediate or jump target).
REQ-015 pc_out  output  32  current fetch PC register.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-017 IDLE: imem_req=0; next cycle -> REQ.
REQ-018 REQ: imem_req=1, imem_addr=pc_out; imem_gnt=1 -> WAIT; else stay REQ with pc_out/imem_addr held stable.
REQ-019 WAIT: imem_req=0; on imem_rvalid, load instr<=imem_rdata, instr_pc<=pc_out, instr_valid<=1, pc_out<=pc_out+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), -> HOLD.
REQ-020 HOLD: instr_valid=1; instr_ready=1 -> instr_valid<=0, -> REQ; else stay HOLD with instr/instr_pc unchanged.
REQ-021 Minimum latency: gnt in cycle N, rvalid earliest N+1, instr_valid=1 from N+2; next request issued no earlier than the cycle after consumption.
REQ-022 Redirect in any state SHALL set pc_out<=redirect_target with bits [1:0] forced to 0, clear instr_valid next cycle, and take priority over every simultaneous event.
REQ-023 Redirect in REQ (granted or not) or HOLD -> REQ next cycle at the new address; any granted request SHALL be killed as in REQ-024.
REQ-024 Redirect while a request is outstanding SHALL set a kill flag; the matching imem_rvalid is discarded (no buffer load, no pc increment), then -> REQ; redirect coincident with rvalid discards that response.
REQ-025 Redirect coincident with instr_ready SHALL drop the buffered instruction; no instruction is delivered for that cycle.
REQ-026 imem_rvalid outside WAIT SHALL be ignored.
REQ-027 instr_valid SHALL never be 1 with an instruction from a killed request.

Reset
REQ-028 While reset=1: state=IDLE, pc_out=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, kill flag=0.
REQ-029 Reset mid-operation SHALL abandon any outstanding request; a late imem_rvalid after reset release SHALL be ignored (state IDLE/REQ).

Verification
REQ-030 Reset release, gnt and rvalid each 1-cycle, instr_ready=1 -> instr_pc sequence 0,4,8 with instr matching memory.
REQ-031 imem_gnt held 0 for 3 cycles in REQ -> imem_req=1, imem_addr=0x0 stable all 3 cycles; fetch completes after gnt.
REQ-032 instr_ready=0 for 5 cycles with instr_valid=1 -> instr/instr_pc stable, imem_req=0; release -> next fetch at instr_pc+4.
REQ-033 redirect=1, redirect_target=0x0000_0103 during WAIT -> response discarded, next imem_addr=0x0000_0100, next instr_pc=0x100.
REQ-034 redirect and instr_ready both 1 in HOLD -> instr_valid=0 next cycle, imem_addr=target, old instruction never re-presented.
REQ-035 redirect_target=0xFFFF_FFFC, rvalid -> pc_out=0x0000_0000; reset asserted in WAIT -> pc_out=RESET_PC, instr_valid=0.
